fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of a main_mem read port; drives one read port as master.
- Holds the PC and issues sequential word reads.
- Buffers returned instruction words with their PCs in a small FIFO, then presents them to decode over a valid/ready handshake.
- Supports redirect (jump/branch) with flush and squash of the in-flight read, plus halt.

Parameters:
- RESET_PC, 8'h10: PC loaded at reset.
- DEPTH, 4: FIFO entries (power of two, 2..16).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; single clock, synchronous, active-high despite the name
- mem_val_o  out  1  read request valid to memory read port
- mem_addr_o  out  8  read address
- mem_rdy_i  in  1  memory accepts request this cycle
- mem_rdata_i  in  16  read data, valid one cycle after acceptance
- redir_i  in  1  redirect request from execute
- redir_pc_i  in  8  redirect target
- halt_i  in  1  stop issuing new reads (level)
- inst_val_o  out  1  instruction available
- inst_o  out  16  instruction word
- inst_pc_o  out  8  PC of inst_o
- inst_rdy_i  in  1  decode consumes head this cycle
- busy_o  out  1  FIFO non-empty or read in flight

Behaviour:
- Reset (rst_ni=1 at posedge): pc=RESET_PC; FIFO empty; inflight=0; squash=0. Outputs mem_val_o=0, mem_addr_o=RESET_PC, inst_val_o=0, inst_o=0, inst_pc_o=0, busy_o=0. Reset mid-operation discards any pending response.
- Memory protocol:
  - Accept = mem_val_o && mem_rdy_i.
  - mem_rdata_i is sampled exactly one cycle after Accept (registered-read memory). mem_rdata_i is ignored at all other times.
- Issue condition: mem_val_o = !rst_ni && !halt_i && !redir_i && (count + inflight < DEPTH). A pop in the same cycle gives no credit.
- mem_addr_o = pc, combinationally. mem_val_o and mem_addr_o hold steady while mem_rdy_i=0.
- On Accept:
  - pc <= pc+1 modulo 256 (8'hFF wraps to 8'h00).
  - inflight <= 1; req_pc <= pc.
  - Back-to-back Accepts are allowed: one request per cycle, each returning the next cycle.
- Response cycle (inflight=1): if !squash, push {req_pc, mem_rdata_i} into the FIFO. inflight clears unless a new Accept occurs in the same cycle.
- Output side:
  - inst_val_o = FIFO non-empty.
  - inst_o / inst_pc_o = head entry; zero when empty.
  - Pop when inst_val_o && inst_rdy_i.
  - Simultaneous push and pop is legal at any count.
- Overflow is impossible by the credit rule. A bench assertion checks count <= DEPTH.
- Redirect (redir_i=1):
  - FIFO flushed; any pop that cycle is ignored.
  - pc <= redir_pc_i.
  - An outstanding read (accepted the previous cycle) is squashed: its response arrives this cycle and is discarded.
  - No request is issued in the redirect cycle; the first request at redir_pc_i goes out the next cycle.
  - redir_i has priority over halt_i, push and pop.
- Halt: halt_i=1 blocks new requests only. An in-flight response still completes and the FIFO still drains. Deasserting halt_i resumes from the current pc.
- Latency without bypass: Accept in cycle N, data in FIFO at edge N+1, inst_val_o=1 in cycle N+2.
- Steady state with inst_rdy_i=1 and mem_rdy_i=1: one instruction per cycle.
- busy_o = inst_val_o || inflight.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined:
  - When the FIFO is empty and a non-squashed response arrives, inst_val_o=1 in that same cycle (N+1), showing mem_rdata_i/req_pc.
  - If inst_rdy_i=1 the word is consumed and not written to the FIFO; otherwise it is written as normal.
  - Credit rule unchanged.
- Undefined: all responses pass through the FIFO (latency N+2).

Test Plan:
- Reset, then run with mem_rdy_i=1 and inst_rdy_i=1 -> reads at 0x10, 0x11, 0x12 on consecutive cycles; first inst_val_o two cycles after the first Accept, inst_pc_o=0x10, then one per cycle.
- inst_rdy_i=0 with DEPTH=4 -> exactly 4 Accepts, then mem_val_o=0 with count=4. Raising inst_rdy_i drains PCs 0x10..0x13 in order and issue resumes at 0x14.
- redir_i with redir_pc_i=0x40 in the cycle a read of 0x15 returns -> data for 0x15 discarded, FIFO empty next cycle, no request that cycle, next request address 0x40, next inst_pc_o=0x40.
- Redirect to 0xFE with free run -> addresses 0xFE, 0xFF, 0x00, 0x01; inst_pc_o follows the same sequence.
- mem_rdy_i held 0 for 3 cycles -> mem_val_o=1 and mem_addr_o stable throughout, no push. halt_i=1 -> mem_val_o=0 while the FIFO still drains and busy_o falls after the last pop.
- FETCH_BYPASS_EN defined, FIFO empty, inst_rdy_i=1 -> inst_val_o=1 one cycle after Accept, no FIFO write. With inst_rdy_i=0 -> word held and presented again the next cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC reads from a registered-read memory, buffered in a FIFO toward decode.
// Optional macro FETCH_BYPASS_EN lets a response reach decode in its arrival cycle when the FIFO is empty.
module fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h10,
    parameter int         DEPTH    = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        mem_val_o,
    output logic [7:0]  mem_addr_o,
    input  logic        mem_rdy_i,
    input  logic [15:0] mem_rdata_i,
    input  logic        redir_i,
    input  logic [7:0]  redir_pc_i,
    input  logic        halt_i,
    output logic        inst_val_o,
    output logic [15:0] inst_o,
    output logic [7:0]  inst_pc_o,
    input  logic        inst_rdy_i,
    output logic        busy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_L = DEPTH[CW:0];

    logic [7:0]    pc_q, pc_d;
    logic [7:0]    req_pc_q, req_pc_d;
    logic          inflight_q, inflight_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [23:0]   fifo_q [DEPTH];

    logic [CW:0]   used;
    logic          accept, resp_ok, fifo_val, push, pop;
    logic [23:0]   head;

    // A pop in the current cycle never frees a credit for issue.
    assign used      = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign mem_val_o = !rst_ni && !halt_i && !redir_i && (used < DEPTH_L);
    assign mem_addr_o = pc_q;
    assign accept    = mem_val_o && mem_rdy_i;
    // A response arriving in a redirect cycle belongs to the old path.
    assign resp_ok   = inflight_q && !redir_i;
    assign fifo_val  = (count_q != '0);
    assign pop       = fifo_val && inst_rdy_i && !redir_i;

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass     = resp_ok && !fifo_val;
    assign push       = resp_ok && !(bypass && inst_rdy_i);
    assign inst_val_o = fifo_val || bypass;
    assign head       = fifo_val ? fifo_q[rd_ptr_q] :
                        (bypass ? {req_pc_q, mem_rdata_i} : 24'h0);
`else
    assign push       = resp_ok;
    assign inst_val_o = fifo_val;
    assign head       = fifo_val ? fifo_q[rd_ptr_q] : 24'h0;
`endif

    assign inst_pc_o = head[23:16];
    assign inst_o    = head[15:0];
    assign busy_o    = inst_val_o || inflight_q;

    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = accept;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (redir_i) begin
            pc_d     = redir_pc_i;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (accept) begin
                pc_d     = pc_q + 8'd1;
                req_pc_d = pc_q;
            end
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni && push) fifo_q[wr_ptr_q] <= {req_pc_q, mem_rdata_i};
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (default build): bench-side registered memory, hand-computed expectations.
module tb_fetch_unit;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        mem_val_o;
    logic [7:0]  mem_addr_o;
    logic        mem_rdy_i;
    logic [15:0] mem_rdata_i;
    logic        redir_i;
    logic [7:0]  redir_pc_i;
    logic        halt_i;
    logic        inst_val_o;
    logic [15:0] inst_o;
    logic [7:0]  inst_pc_o;
    logic        inst_rdy_i;
    logic        busy_o;

    int checks = 0;
    int errors = 0;
    int n_acc;
    logic [7:0] wrap_seq [6];

    fetch_unit #(.RESET_PC(8'h10), .DEPTH(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .mem_val_o(mem_val_o), .mem_addr_o(mem_addr_o), .mem_rdy_i(mem_rdy_i),
        .mem_rdata_i(mem_rdata_i), .redir_i(redir_i), .redir_pc_i(redir_pc_i),
        .halt_i(halt_i), .inst_val_o(inst_val_o), .inst_o(inst_o),
        .inst_pc_o(inst_pc_o), .inst_rdy_i(inst_rdy_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return {a ^ 8'h5A, a};
    endfunction

    // Advance one clock; the memory answers one cycle after an accepted request, junk otherwise.
    task automatic tick();
        logic acc;
        logic [7:0] a;
        acc = mem_val_o && mem_rdy_i;
        a   = mem_addr_o;
        @(posedge clk_i);
        #1;
        mem_rdata_i = acc ? mem_word(a) : 16'hDEAD;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b1; halt_i = 1'b0; redir_i = 1'b0; redir_pc_i = 8'h00;
        mem_rdy_i = 1'b0; inst_rdy_i = 1'b0; mem_rdata_i = 16'hDEAD;
        tick();
        tick();
        chk("rst_mem_val", 32'(mem_val_o), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr_o), 32'h10);
        chk("rst_inst_val", 32'(inst_val_o), 32'd0);
        chk("rst_inst", 32'(inst_o), 32'd0);
        chk("rst_inst_pc", 32'(inst_pc_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rst_ni = 1'b0;
        #1;
    endtask

    initial begin
        wrap_seq[0] = 8'hFE; wrap_seq[1] = 8'hFF; wrap_seq[2] = 8'h00;
        wrap_seq[3] = 8'h01; wrap_seq[4] = 8'h02; wrap_seq[5] = 8'h03;

        // Free run: sequential reads, first instruction two cycles after first accept.
        do_reset();
        mem_rdy_i = 1'b1; inst_rdy_i = 1'b1; #1;
        chk("run_val0", 32'(mem_val_o), 32'd1);
        chk("run_addr0", 32'(mem_addr_o), 32'h10);
        tick();
        chk("run_addr1", 32'(mem_addr_o), 32'h11);
        chk("run_ival1", 32'(inst_val_o), 32'd0);
        chk("run_busy1", 32'(busy_o), 32'd1);
        tick();
        chk("run_addr2", 32'(mem_addr_o), 32'h12);
        chk("run_ival2", 32'(inst_val_o), 32'd1);
        chk("run_ipc2", 32'(inst_pc_o), 32'h10);
        chk("run_inst2", 32'(inst_o), 32'(mem_word(8'h10)));
        tick();
        chk("run_ipc3", 32'(inst_pc_o), 32'h11);
        chk("run_inst3", 32'(inst_o), 32'(mem_word(8'h11)));
        tick();
        chk("run_ipc4", 32'(inst_pc_o), 32'h12);
        tick();
        chk("run_ipc5", 32'(inst_pc_o), 32'h13);
        tick();
        // Redirect while the read of 0x15 returns.
        chk("redir_head", 32'(inst_pc_o), 32'h14);
        redir_i = 1'b1; redir_pc_i = 8'h40; #1;
        chk("redir_no_issue", 32'(mem_val_o), 32'd0);
        chk("redir_busy", 32'(busy_o), 32'd1);
        tick();
        redir_i = 1'b0; #1;
        chk("redir_flush", 32'(inst_val_o), 32'd0);
        chk("redir_busy_after", 32'(busy_o), 32'd0);
        chk("redir_val", 32'(mem_val_o), 32'd1);
        chk("redir_addr", 32'(mem_addr_o), 32'h40);
        tick();
        chk("redir_ival8", 32'(inst_val_o), 32'd0);
        chk("redir_addr8", 32'(mem_addr_o), 32'h41);
        tick();
        chk("redir_ival9", 32'(inst_val_o), 32'd1);
        chk("redir_ipc9", 32'(inst_pc_o), 32'h40);
        chk("redir_inst9", 32'(inst_o), 32'(mem_word(8'h40)));
        // Redirect to 0xFE and follow the wrap through 0x00.
        redir_i = 1'b1; redir_pc_i = 8'hFE; #1;
        tick();
        redir_i = 1'b0; #1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) chk($sformatf("wrap_addr%0d", i), 32'(mem_addr_o), 32'(wrap_seq[i]));
            if (i < 2) chk($sformatf("wrap_ival%0d", i), 32'(inst_val_o), 32'd0);
            if (i >= 2) chk($sformatf("wrap_ipc%0d", i), 32'(inst_pc_o), 32'(wrap_seq[i-2]));
            tick();
        end

        // Back-pressure from decode: credits stop issue at exactly DEPTH.
        do_reset();
        mem_rdy_i = 1'b1; inst_rdy_i = 1'b0; #1;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            if (mem_val_o && mem_rdy_i) n_acc++;
            tick();
        end
        chk("full_accepts", 32'(n_acc), 32'd4);
        chk("full_val", 32'(mem_val_o), 32'd0);
        chk("full_addr", 32'(mem_addr_o), 32'h14);
        chk("full_busy", 32'(busy_o), 32'd1);
        chk("full_count_le_depth", 32'(dut.count_q <= 4), 32'd1);
        inst_rdy_i = 1'b1; #1;
        chk("drain_no_credit", 32'(mem_val_o), 32'd0);
        chk("drain_ipc0", 32'(inst_pc_o), 32'h10);
        tick();
        chk("drain_ipc1", 32'(inst_pc_o), 32'h11);
        chk("drain_resume_val", 32'(mem_val_o), 32'd1);
        chk("drain_resume_addr", 32'(mem_addr_o), 32'h14);
        tick();
        chk("drain_ipc2", 32'(inst_pc_o), 32'h12);
        tick();
        chk("drain_ipc3", 32'(inst_pc_o), 32'h13);

        // Memory stall: request held steady, nothing pushed.
        do_reset();
        mem_rdy_i = 1'b0; inst_rdy_i = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall_val%0d", i), 32'(mem_val_o), 32'd1);
            chk($sformatf("stall_addr%0d", i), 32'(mem_addr_o), 32'h10);
            chk($sformatf("stall_ival%0d", i), 32'(inst_val_o), 32'd0);
            chk($sformatf("stall_busy%0d", i), 32'(busy_o), 32'd0);
            tick();
        end
        mem_rdy_i = 1'b1; #1;
        tick();
        mem_rdy_i = 1'b0; #1;
        chk("stall_addr_next", 32'(mem_addr_o), 32'h11);
        chk("stall_busy_inflight", 32'(busy_o), 32'd1);
        chk("stall_ival_inflight", 32'(inst_val_o), 32'd0);
        tick();
        chk("stall_ival_data", 32'(inst_val_o), 32'd1);
        chk("stall_ipc_data", 32'(inst_pc_o), 32'h10);
        tick();
        chk("stall_ival_done", 32'(inst_val_o), 32'd0);
        chk("stall_busy_done", 32'(busy_o), 32'd0);
        chk("stall_addr_done", 32'(mem_addr_o), 32'h11);

        // Halt: issue stops, in-flight completes, FIFO drains, resume at current pc.
        do_reset();
        mem_rdy_i = 1'b1; inst_rdy_i = 1'b0; #1;
        tick();
        tick();
        halt_i = 1'b1; #1;
        chk("halt_val", 32'(mem_val_o), 32'd0);
        chk("halt_busy", 32'(busy_o), 32'd1);
        tick();
        chk("halt_val2", 32'(mem_val_o), 32'd0);
        chk("halt_ipc2", 32'(inst_pc_o), 32'h10);
        inst_rdy_i = 1'b1; #1;
        tick();
        chk("halt_ipc3", 32'(inst_pc_o), 32'h11);
        chk("halt_busy3", 32'(busy_o), 32'd1);
        chk("halt_val3", 32'(mem_val_o), 32'd0);
        tick();
        chk("halt_ival4", 32'(inst_val_o), 32'd0);
        chk("halt_busy4", 32'(busy_o), 32'd0);
        chk("halt_addr4", 32'(mem_addr_o), 32'h12);
        halt_i = 1'b0; #1;
        chk("resume_val", 32'(mem_val_o), 32'd1);
        chk("resume_addr", 32'(mem_addr_o), 32'h12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
